cmd_framer_v: RTL and testbench

CMD_FRAMER_V -- requirements
Module: cmd_framer_v

---
 rtl/cmd_framer_v.sv | 181 ++++++++++++++++++
 tb/tb_cmd_framer_v.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_framer_v.sv
// Assembles ASCII characters into "[digit:]command" frames and emits the
// packed command plus optional user id as a short o_rdy pulse.
module cmd_framer_v #(
  parameter int                      I_A_NUM_ASCII_CHARS = 7,
  parameter int                      I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS*8,
  parameter int                      I_U_NUM_BITS        = 4,
  parameter logic [I_U_NUM_BITS-1:0] U_NONE              = 4'hF,
  parameter int                      RDY_CYCLES          = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_char_vld,
  input  logic [7:0]              i_char,
  output logic                    o_char_rdy,
  output logic [I_U_NUM_BITS-1:0] o_u,
  output logic [I_A_NUM_BITS-1:0] o_a,
  output logic                    o_rdy,
  output logic                    o_err
);

  localparam int CW = $clog2(I_A_NUM_ASCII_CHARS + 1);

  typedef enum logic [2:0] {FIRST, SEP, CMD, DROP, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cand_q, cand_d;
  logic [I_U_NUM_BITS-1:0] user_q, user_d;
  logic [I_A_NUM_BITS-1:0] cmd_q, cmd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [I_A_NUM_BITS-1:0] a_q, a_d;
  logic [I_U_NUM_BITS-1:0] u_q, u_d;
  logic [3:0]              rdyCnt_q, rdyCnt_d;
  logic                    err_q, err_d;
  logic                    alive_q;

  logic accept, isTerm, isBs, isPrint, isDigit, clearFrame;

  assign isTerm  = (i_char == 8'h0A) || (i_char == 8'h0D);
  assign isBs    = (i_char == 8'h08);
  assign isPrint = (i_char >= 8'h20) && (i_char <= 8'h7E);
  assign isDigit = (i_char >= 8'h30) && (i_char <= 8'h39);

  // alive_q keeps o_char_rdy low until the first clock edge after reset release.
  assign o_char_rdy = alive_q && (state_q != EMIT);
  assign accept     = i_char_vld && o_char_rdy;
  assign o_rdy      = (state_q == EMIT);
  assign o_err      = err_q;
  assign o_a        = a_q;
  assign o_u        = u_q;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    user_d     = user_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    u_d        = u_q;
    rdyCnt_d   = rdyCnt_q;
    err_d      = 1'b0;
    clearFrame = 1'b0;

    case (state_q)
      FIRST: begin
        if (accept) begin
          if (isDigit) begin
            cand_d  = i_char;
            state_d = SEP;
          end else if (isPrint) begin
            cmd_d   = I_A_NUM_BITS'(i_char);
            cnt_d   = CW'(1);
            state_d = CMD;
          end
        end
      end

      SEP: begin
        if (accept) begin
          if (i_char == 8'h3A) begin
            user_d  = I_U_NUM_BITS'(cand_q[3:0]);
            cmd_d   = '0;
            cnt_d   = '0;
            state_d = CMD;
          end else if (isPrint) begin
            cmd_d   = I_A_NUM_BITS'({cand_q, i_char});
            cnt_d   = CW'(2);
            user_d  = U_NONE;
            state_d = CMD;
          end else if (isTerm) begin
            a_d      = I_A_NUM_BITS'(cand_q);
            u_d      = U_NONE;
            rdyCnt_d = 4'(RDY_CYCLES - 1);
            state_d  = EMIT;
          end else if (isBs) begin
            // Erasing the lone digit leaves an empty line.
            clearFrame = 1'b1;
          end
        end
      end

      CMD: begin
        if (accept) begin
          if (isPrint) begin
            if (cnt_q == CW'(I_A_NUM_ASCII_CHARS)) begin
              state_d = DROP;
            end else begin
              cmd_d = {cmd_q[I_A_NUM_BITS-9:0], i_char};
              cnt_d = cnt_q + CW'(1);
            end
          end else if (isBs) begin
            if (cnt_q != '0) begin
              cmd_d = cmd_q >> 8;
              cnt_d = cnt_q - CW'(1);
            end
          end else if (isTerm) begin
            if (cnt_q != '0) begin
              a_d      = cmd_q;
              u_d      = user_q;
              rdyCnt_d = 4'(RDY_CYCLES - 1);
              state_d  = EMIT;
            end else begin
              clearFrame = 1'b1;
            end
          end
        end
      end

      DROP: begin
        if (accept && isTerm) begin
          err_d      = 1'b1;
          clearFrame = 1'b1;
        end
      end

      EMIT: begin
        if (rdyCnt_q == 4'd0) begin
          clearFrame = 1'b1;
        end else begin
          rdyCnt_d = rdyCnt_q - 4'd1;
        end
      end

      default: clearFrame = 1'b1;
    endcase

    if (clearFrame) begin
      state_d = FIRST;
      cand_d  = '0;
      user_d  = U_NONE;
      cmd_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= FIRST;
      cand_q   <= '0;
      user_q   <= U_NONE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      u_q      <= U_NONE;
      rdyCnt_q <= '0;
      err_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      user_q   <= user_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      u_q      <= u_d;
      rdyCnt_q <= rdyCnt_d;
      err_q    <= err_d;
      alive_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_framer_v.sv
// Directed bench for cmd_framer_v: a frame table on the default instance,
// plus reset-mid-frame and RDY_CYCLES=3 back-pressure sequences.
module tb_cmd_framer_v;

  logic        clock = 1'b0;
  logic        rstN;
  logic        charVld, charVld3;
  logic [7:0]  charIn, charIn3;
  logic        charRdy, charRdy3;
  logic [3:0]  outU, outU3;
  logic [55:0] outA, outA3;
  logic        outRdy, outRdy3;
  logic        outErr, outErr3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cmd_framer_v dut (
    .i_clk(clock), .i_reset(rstN), .i_char_vld(charVld), .i_char(charIn),
    .o_char_rdy(charRdy), .o_u(outU), .o_a(outA), .o_rdy(outRdy), .o_err(outErr)
  );

  cmd_framer_v #(.RDY_CYCLES(3)) dut3 (
    .i_clk(clock), .i_reset(rstN), .i_char_vld(charVld3), .i_char(charIn3),
    .o_char_rdy(charRdy3), .o_u(outU3), .o_a(outA3), .o_rdy(outRdy3), .o_err(outErr3)
  );

  // Running pulse counters for the default instance, sampled mid-cycle.
  int rdyCount = 0, errCount = 0, rdyWithCharRdy = 0;
  always @(negedge clock) begin
    if (outRdy) begin
      rdyCount <= rdyCount + 1;
      if (charRdy) rdyWithCharRdy <= rdyWithCharRdy + 1;
    end
    if (outErr) errCount <= errCount + 1;
  end

  // Records each o_rdy run of the RDY_CYCLES=3 instance: emitted value and length.
  logic        prev3 = 1'b0;
  int          n3 = 0;
  int          err3 = 0;
  logic [55:0] emitA3 [4];
  int          runLen3 [4];
  always @(negedge clock) begin
    prev3 <= outRdy3;
    if (outErr3) err3 <= err3 + 1;
    if (outRdy3 && !prev3 && n3 < 4) begin
      emitA3[n3]  <= outA3;
      runLen3[n3] <= 1;
      n3          <= n3 + 1;
    end else if (outRdy3 && prev3 && n3 > 0) begin
      runLen3[n3-1] <= runLen3[n3-1] + 1;
    end
  end

  typedef struct {
    logic [127:0] frame;
    logic [55:0]  expA;
    logic [3:0]   expU;
    int           expRdy;
    int           expErr;
  } vec_t;

  vec_t vecs [13];

  function automatic int frameLen(input logic [127:0] f);
    int n = 0;
    for (int i = 0; i < 16; i++) if (f[8*i +: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sends a frame byte by byte, waiting for o_char_rdy before each accept.
  task automatic applyStimulus(input logic [127:0] f);
    int len = frameLen(f);
    for (int i = len - 1; i >= 0; i--) begin
      int g = 0;
      @(negedge clock);
      charVld = 1'b1;
      charIn  = f[8*i +: 8];
      while (!charRdy && g < 50) begin
        @(negedge clock);
        g++;
      end
      if (g >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL charRdyTimeout: got 0, expected 1");
      end
      @(posedge clock);
    end
    @(negedge clock);
    charVld = 1'b0;
    charIn  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, e0, w0, g, idx;
    logic take;
    logic [127:0] s3;

    vecs[0]  = '{"Login\n",         56'h00004C6F67696E, 4'hF, 1, 0};
    vecs[1]  = '{"3:Buy\r",         56'h427579,         4'h3, 1, 0};
    vecs[2]  = '{"7:\n",            56'h427579,         4'h3, 0, 0};
    vecs[3]  = '{"AddItemX\n",      56'h427579,         4'h3, 0, 1};
    vecs[4]  = '{"NONE\n",          56'h4E4F4E45,       4'hF, 1, 0};
    vecs[5]  = '{"Lox\010gin\n",    56'h4C6F67696E,     4'hF, 1, 0};
    vecs[6]  = '{"5\n",             56'h35,             4'hF, 1, 0};
    vecs[7]  = '{"\n",              56'h35,             4'hF, 0, 0};
    vecs[8]  = '{"AddItem\n",       56'h4164644974656D, 4'hF, 1, 0};
    vecs[9]  = '{"12\n",            56'h3132,           4'hF, 1, 0};
    vecs[10] = '{"9:X\n",           56'h58,             4'h9, 1, 0};
    vecs[11] = '{"\001Hi\n",        56'h4869,           4'hF, 1, 0};
    vecs[12] = '{"4:\010Z\n",       56'h5A,             4'h4, 1, 0};

    charVld  = 1'b0;
    charIn   = 8'h00;
    charVld3 = 1'b0;
    charIn3  = 8'h00;
    rstN     = 1'b1;
    #1 rstN  = 1'b0;
    #11;
    checkOutput("reset o_a", 64'(outA), 64'h0);
    checkOutput("reset o_u", 64'(outU), 64'hF);
    checkOutput("reset o_rdy", 64'(outRdy), 64'h0);
    checkOutput("reset o_err", 64'(outErr), 64'h0);
    checkOutput("reset o_char_rdy", 64'(charRdy), 64'h0);

    @(negedge clock);
    rstN = 1'b1;
    #1 checkOutput("char_rdy before first edge", 64'(charRdy), 64'h0);
    @(posedge clock);
    #1 checkOutput("char_rdy after first edge", 64'(charRdy), 64'h1);

    for (int i = 0; i < 13; i++) begin
      r0 = rdyCount;
      e0 = errCount;
      w0 = rdyWithCharRdy;
      applyStimulus(vecs[i].frame);
      repeat (6) @(negedge clock);
      #1;
      checkOutput($sformatf("v%0d rdy cycles", i), 64'(rdyCount - r0), 64'(vecs[i].expRdy));
      checkOutput($sformatf("v%0d err cycles", i), 64'(errCount - e0), 64'(vecs[i].expErr));
      checkOutput($sformatf("v%0d o_a", i), 64'(outA), 64'(vecs[i].expA));
      checkOutput($sformatf("v%0d o_u", i), 64'(outU), 64'(vecs[i].expU));
      checkOutput($sformatf("v%0d char_rdy in emit", i), 64'(rdyWithCharRdy - w0), 64'h0);
    end

    // Reset asserted mid-cycle in the middle of a partial frame.
    applyStimulus("Add");
    @(negedge clock);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset o_a", 64'(outA), 64'h0);
    checkOutput("midreset o_u", 64'(outU), 64'hF);
    checkOutput("midreset o_char_rdy", 64'(charRdy), 64'h0);
    checkOutput("midreset o_rdy", 64'(outRdy), 64'h0);
    #4 rstN = 1'b1;
    r0 = rdyCount;
    applyStimulus("Buy\n");
    repeat (4) @(negedge clock);
    #1;
    checkOutput("after reset o_a", 64'(outA), 64'h427579);
    checkOutput("after reset o_u", 64'(outU), 64'hF);
    checkOutput("after reset rdy cycles", 64'(rdyCount - r0), 64'h1);

    // RDY_CYCLES=3 instance with i_char_vld held high straight through EMIT.
    s3  = "Go\nAb\n";
    idx = 0;
    g   = 0;
    while (idx < 6 && g < 200) begin
      @(negedge clock);
      charVld3 = 1'b1;
      charIn3  = s3[8*(5-idx) +: 8];
      take     = charRdy3;
      @(posedge clock);
      if (take) idx++;
      g++;
    end
    @(negedge clock);
    charVld3 = 1'b0;
    charIn3  = 8'h00;
    if (g >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream3 timeout: got %0d chars, expected 6", idx);
    end
    repeat (8) @(negedge clock);
    #1;
    checkOutput("rdy3 emissions", 64'(n3), 64'h2);
    checkOutput("rdy3 err pulses", 64'(err3), 64'h0);
    if (n3 >= 2) begin
      checkOutput("rdy3 first o_a", 64'(emitA3[0]), 64'h476F);
      checkOutput("rdy3 first run", 64'(runLen3[0]), 64'h3);
      checkOutput("rdy3 second o_a", 64'(emitA3[1]), 64'h4162);
      checkOutput("rdy3 second run", 64'(runLen3[1]), 64'h3);
    end
    checkOutput("rdy3 held o_a", 64'(outA3), 64'h4162);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
